// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle, width-generic shifter/rotator with valid/ready
// handshakes on both sides. Shifts the captured operand by up to STEP bits
// per clock until the requested amount is consumed, then holds the result
// until the consumer takes it.
// Optional build macro: SHIFTER_FLAGS_EN adds the c_out (last bit shifted
// out) and z_out (result is zero) flag ports.
module seq_shifter #(
  parameter int W    = 16,
  parameter int SHW  = 4,
  parameter int STEP = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [SHW-1:0] in_amt,
  input  logic [1:0]     in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           busy
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic           c_out,
  output logic           z_out
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_LSL = 2'b00,
    M_LSR = 2'b01,
    M_ASR = 2'b10,
    M_ROR = 2'b11
  } mode_t;

  localparam logic [SHW-1:0] STEP_L = SHW'(STEP);
  localparam logic [SHW:0]   W_L    = (SHW + 1)'(W);

  state_t         r_state;
  state_t         w_next;
  mode_t          r_mode;
  logic [W-1:0]   r_work;
  logic [SHW-1:0] r_rem;
  logic [W-1:0]   r_out_data;

  logic [SHW-1:0] w_k;
  logic [SHW-1:0] w_rem_nxt;
  logic [SHW:0]   w_lsh;
  logic [W-1:0]   w_shifted;

  // Handshake and status outputs decode straight from registered state, so
  // there is never a combinational path from an input to an output.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out_data;

  // One shift step: k = min(STEP, rem) bits with the mode's fill rule.
  always_comb begin
    w_k       = (r_rem < STEP_L) ? r_rem : STEP_L;
    w_rem_nxt = r_rem - w_k;
    // Complementary amount for the rotate wrap; k >= 1 in SHIFT, so W-k < W.
    w_lsh     = W_L - {1'b0, w_k};
    unique case (r_mode)
      M_LSL:   w_shifted = r_work << w_k;
      M_LSR:   w_shifted = r_work >> w_k;
      // The work MSB never changes under ASR, so it keeps replicating the
      // sign bit captured at accept time.
      M_ASR:   w_shifted = W'($signed(r_work) >>> w_k);
      default: w_shifted = (r_work >> w_k) | (r_work << w_lsh);
    endcase
  end

  // State register; reset overrides everything, including a shift in flight.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // together from pre-edge values, whatever order the statements are in.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first, so every path assigns w_next and no latch forms.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_next = (in_amt == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (w_rem_nxt == '0) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, step while shifting, publish on DONE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_work     <= '0;
      r_rem      <= '0;
      r_mode     <= M_LSL;
      r_out_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work <= in_data;
            r_rem  <= in_amt;
            r_mode <= mode_t'(in_mode);
            if (in_amt == '0) r_out_data <= in_data;
          end
        end
        S_SHIFT: begin
          r_work <= w_shifted;
          r_rem  <= w_rem_nxt;
          if (w_rem_nxt == '0) r_out_data <= w_shifted;
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFTER_FLAGS_EN
  logic w_carry;

  // Bit leaving the word on this step. For ROR it is the bit that wraps
  // into the MSB, i.e. result bit W-1 once the last step is taken.
  always_comb begin
    if (r_mode == M_LSL) w_carry = r_work[w_lsh[SHW-1:0]];
    else                 w_carry = r_work[w_k - 1'b1];
  end

  // Flags are published together with out_data on DONE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_out <= 1'b0;
      z_out <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid && in_amt == '0) begin
            c_out <= 1'b0;
            z_out <= (in_data == '0);
          end
        end
        S_SHIFT: begin
          if (w_rem_nxt == '0) begin
            c_out <= w_carry;
            z_out <= (w_shifted == '0);
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: one instance with STEP=1, one with STEP=4.
// Expected results, latencies and flags are hand-computed constants.
module tb_seq_shifter;

  localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_data  [2];
  logic [3:0]  in_amt   [2];
  logic [1:0]  in_mode  [2];
  logic [15:0] out_data [2];
  logic [1:0]  c_out, z_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_shifter #(.W(16), .SHW(4), .STEP(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_amt(in_amt[0]), .in_mode(in_mode[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0])
`ifdef SHIFTER_FLAGS_EN
    , .c_out(c_out[0]), .z_out(z_out[0])
`endif
  );

  seq_shifter #(.W(16), .SHW(4), .STEP(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_amt(in_amt[1]), .in_mode(in_mode[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1])
`ifdef SHIFTER_FLAGS_EN
    , .c_out(c_out[1]), .z_out(z_out[1])
`endif
  );

`ifndef SHIFTER_FLAGS_EN
  assign c_out = 2'b00;
  assign z_out = 2'b00;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on instance s, measure latency, check result and
  // flags, then hand the result off and confirm return to IDLE.
  task automatic run(input int s, input string tag, input logic [15:0] d,
                     input logic [3:0] amt, input logic [1:0] mode,
                     input logic [15:0] exp, input int exp_lat,
                     input logic exp_c, input logic exp_z);
    int lat;
    in_data[s]  = d;
    in_amt[s]   = amt;
    in_mode[s]  = mode;
    in_valid[s] = 1'b1;
    tick();
    in_valid[s] = 1'b0;
    lat = 0;
    while (!out_valid[s] && lat < 40) begin
      check({tag, "_busy"}, 32'(busy[s]), 32'd1);
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(out_data[s]), 32'(exp));
    check({tag, "_busy_done"}, 32'(busy[s]), 32'd1);
`ifdef SHIFTER_FLAGS_EN
    check({tag, "_c"}, 32'(c_out[s]), 32'(exp_c));
    check({tag, "_z"}, 32'(z_out[s]), 32'(exp_z));
`endif
    out_ready[s] = 1'b1;
    tick();
    out_ready[s] = 1'b0;
    check({tag, "_idle"}, {30'd0, in_ready[s], out_valid[s]}, 32'b10);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 2; i++) begin
      in_data[i] = '0;
      in_amt[i]  = '0;
      in_mode[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check("rst_ctrl", {28'd0, in_ready[i], out_valid[i], busy[i], 1'b0}, 32'b1000);
      check("rst_data", 32'(out_data[i]), 32'd0);
      check("rst_flags", {30'd0, c_out[i], z_out[i]}, 32'd0);
    end
    reset = 1'b0;
    tick();

    // STEP = 1
    run(0, "lsl1",    16'h8001, 4'd1,  LSL, 16'h0002, 1,  1'b1, 1'b0);
    run(0, "asr15",   16'h8000, 4'd15, ASR, 16'hFFFF, 15, 1'b0, 1'b0);
    run(0, "lsr15",   16'h8000, 4'd15, LSR, 16'h0001, 15, 1'b0, 1'b0);
    run(0, "amt0",    16'hA5A5, 4'd0,  ROR, 16'hA5A5, 0,  1'b0, 1'b0);
    run(0, "ror4",    16'h0001, 4'd4,  ROR, 16'h1000, 4,  1'b0, 1'b0);
    run(0, "ror15",   16'h8421, 4'd15, ROR, 16'h0843, 15, 1'b0, 1'b0);
    run(0, "lsl15",   16'hFFFF, 4'd15, LSL, 16'h8000, 15, 1'b1, 1'b0);
    run(0, "lsr_z",   16'h0001, 4'd1,  LSR, 16'h0000, 1,  1'b1, 1'b1);

    // STEP = 4
    run(1, "s4_lsr7", 16'hF000, 4'd7,  LSR, 16'h01E0, 2,  1'b0, 1'b0);
    run(1, "s4_ror",  16'h8421, 4'd15, ROR, 16'h0843, 4,  1'b0, 1'b0);
    run(1, "s4_lsl5", 16'h0003, 4'd5,  LSL, 16'h0060, 2,  1'b0, 1'b0);
    run(1, "s4_asr9", 16'h8000, 4'd9,  ASR, 16'hFFC0, 3,  1'b0, 1'b0);

    // Backpressure: LSL 0x0003 by 2, then hold the result for 5 cycles
    // while a second request is offered and must be ignored.
    in_data[0] = 16'h0003; in_amt[0] = 4'd2; in_mode[0] = LSL;
    in_valid[0] = 1'b1;
    tick();
    in_data[0] = 16'h0001; in_amt[0] = 4'd1; in_mode[0] = LSL;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_ctrl", {29'd0, out_valid[0], in_ready[0], busy[0]}, 32'b101);
      check("bp_data", 32'(out_data[0]), 32'h000C);
      tick();
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    check("bp_idle", {30'd0, in_ready[0], out_valid[0]}, 32'b10);
    tick();
    check("bp_accept", {30'd0, in_ready[0], busy[0]}, 32'b01);
    in_valid[0] = 1'b0;
    tick();
    check("bp_new_valid", 32'(out_valid[0]), 32'd1);
    check("bp_new_data", 32'(out_data[0]), 32'h0002);
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;

    // Reset in the middle of a 15-bit ASR.
    in_data[0] = 16'h8000; in_amt[0] = 4'd15; in_mode[0] = ASR;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_busy", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ctrl", {29'd0, in_ready[0], out_valid[0], busy[0]}, 32'b100);
    check("mid_rst_data", 32'(out_data[0]), 32'd0);
    run(0, "post_rst", 16'h0003, 4'd2, LSL, 16'h000C, 2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
